// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph table, widths and FSM encoding shared by the 7-segment encoder and decoder
package seg_pkg;

   localparam int SEG_W = 7;
   localparam int NIB_W = 4;
   localparam int GLYPH_N = 16;

   // Bit order gfedcba, 1 = segment lit
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
   localparam logic [SEG_W-1:0] GLYPH [GLYPH_N] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/seg_pattern_lut.sv
// rtl/seg_pattern_lut.sv - combinational reverse glyph lookup: pattern -> {hit, blank, nibble}
module seg_pattern_lut
   import seg_pkg::*;
(
   input  logic [SEG_W-1:0] pat,
   output logic             hit,
   output logic             blank,
   output logic [NIB_W-1:0] nibble
);

   always_comb begin
      hit    = 1'b0;
      nibble = '0;
      for (int i = 0; i < GLYPH_N; i++) begin
         if (pat == GLYPH[i]) begin
            hit    = 1'b1;
            nibble = NIB_W'(i);
         end
      end
      blank = (pat == SEG_BLANK);
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - multiplexed 7-segment bus monitor that recovers the nibble per digit
// Optional saturating bad-pattern counter enabled by SEG_DECODER_ERRCNT_EN.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEG_W-1:0]      seg_in,
   input  logic [DIGITS-1:0]     sel_in,
   output logic [4*DIGITS-1:0]   digit_out,
   output logic [DIGITS-1:0]     digit_vld,
   output logic                  upd,
   output logic [2:0]            upd_idx,
   output logic                  bad_pat
`ifdef SEG_DECODER_ERRCNT_EN
   ,
   output logic [7:0]            err_cnt
`endif
);

   localparam int BUS_W = DIGITS + SEG_W;
   localparam int CW    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   logic [BUS_W-1:0]    s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [1:0]          state_q, state_d;
   logic [4*DIGITS-1:0] digit_out_q, digit_out_d;
   logic [DIGITS-1:0]   digit_vld_q, digit_vld_d;
   logic                upd_q, upd_d;
   logic [2:0]          upd_idx_q, upd_idx_d;
   logic                bad_q, bad_d;

   logic [DIGITS-1:0]   sel_s2;
   logic [SEG_W-1:0]    seg_s2;
   logic                one_hot;
   logic                changed;
   logic                commit;
   logic                lut_hit, lut_blank;
   logic [NIB_W-1:0]    lut_nibble;

   assign sel_s2  = s2_q[BUS_W-1:SEG_W];
   assign seg_s2  = s2_q[SEG_W-1:0];
   assign one_hot = (sel_s2 != '0) && ((sel_s2 & (sel_s2 - DIGITS'(1))) == '0);
   assign changed = (s2_q != prev_q);

   seg_pattern_lut u_lut (
      .pat    (seg_s2),
      .hit    (lut_hit),
      .blank  (lut_blank),
      .nibble (lut_nibble)
   );

   // Commit is decided on the counter's next value so upd/bad_pat register on the edge it saturates
   always_comb begin
      s1_d    = {sel_in, seg_in};
      s2_d    = s1_q;
      prev_d  = s2_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      if (!one_hot) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         if (changed)
            cnt_d = '0;
         else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);
         case (state_q)
            ST_IDLE:   state_d = ST_SETTLE;
            ST_SETTLE: begin
               if (cnt_d == CNT_MAX) begin
                  state_d = ST_LOCKED;
                  commit  = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (changed)
                  state_d = ST_SETTLE;
            end
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      digit_out_d = digit_out_q;
      digit_vld_d = digit_vld_q;
      upd_idx_d   = upd_idx_q;
      upd_d       = 1'b0;
      bad_d       = 1'b0;
      if (commit) begin
         if (lut_hit || lut_blank) begin
            upd_d = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
               if (sel_s2[i]) begin
                  upd_idx_d = 3'(i);
                  if (lut_hit) begin
                     digit_out_d[4*i +: 4] = lut_nibble;
                     digit_vld_d[i]        = 1'b1;
                  end else begin
                     digit_vld_d[i]        = 1'b0;
                  end
               end
            end
         end else begin
            bad_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q        <= '0;
         s2_q        <= '0;
         prev_q      <= '0;
         cnt_q       <= '0;
         state_q     <= ST_IDLE;
         digit_out_q <= '0;
         digit_vld_q <= '0;
         upd_q       <= 1'b0;
         upd_idx_q   <= '0;
         bad_q       <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         digit_out_q <= digit_out_d;
         digit_vld_q <= digit_vld_d;
         upd_q       <= upd_d;
         upd_idx_q   <= upd_idx_d;
         bad_q       <= bad_d;
      end
   end

   assign digit_out = digit_out_q;
   assign digit_vld = digit_vld_q;
   assign upd       = upd_q;
   assign upd_idx   = upd_idx_q;
   assign bad_pat   = bad_q;

`ifdef SEG_DECODER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (bad_d && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt_q <= '0;
      else
         err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  sel_in;
   logic [15:0] digit_out;
   logic [3:0]  digit_vld;
   logic        upd;
   logic [2:0]  upd_idx;
   logic        bad_pat;
`ifdef SEG_DECODER_ERRCNT_EN
   logic [7:0]  err_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int n_upd, at_upd, n_bad, at_bad;
   int overlap  = 0;

   seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .sel_in    (sel_in),
      .digit_out (digit_out),
      .digit_vld (digit_vld),
      .upd       (upd),
      .upd_idx   (upd_idx),
      .bad_pat   (bad_pat)
`ifdef SEG_DECODER_ERRCNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Edge k = 0 is the first posedge after the call; inputs are sampled there
   task automatic run_edges(input int n, input int glitch_k, input logic [6:0] glitch_seg);
      logic [6:0] saved;
      saved  = seg_in;
      n_upd  = 0;
      at_upd = -1;
      n_bad  = 0;
      at_bad = -1;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (upd) begin n_upd++; at_upd = k; end
         if (bad_pat) begin n_bad++; at_bad = k; end
         if (upd && bad_pat) overlap++;
         if (k == glitch_k) seg_in = glitch_seg;
         if (glitch_k >= 0 && k == glitch_k + 1) seg_in = saved;
      end
   endtask

   task automatic test_reset;
      rst    = 1'b1;
      seg_in = 7'b0;
      sel_in = 4'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (digit_out !== 16'h0) begin failures++; $display("FAIL reset_digit_out: got %h exp 0000", digit_out); end
      checks++; if (digit_vld !== 4'h0) begin failures++; $display("FAIL reset_digit_vld: got %b exp 0000", digit_vld); end
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd: got %b exp 0", upd); end
      checks++; if (upd_idx !== 3'd0) begin failures++; $display("FAIL reset_upd_idx: got %0d exp 0", upd_idx); end
      checks++; if (bad_pat !== 1'b0) begin failures++; $display("FAIL reset_bad_pat: got %b exp 0", bad_pat); end
`ifdef SEG_DECODER_ERRCNT_EN
      checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt: got %0d exp 0", err_cnt); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_basic_commit;
      sel_in = 4'b0001;
      seg_in = 7'b1001111;
      run_edges(12, -1, 7'b0);
      checks++; if (n_upd !== 1) begin failures++; $display("FAIL basic_upd_count: got %0d exp 1", n_upd); end
      checks++; if (at_upd !== 10) begin failures++; $display("FAIL basic_upd_edge: got %0d exp 10", at_upd); end
      checks++; if (upd_idx !== 3'd0) begin failures++; $display("FAIL basic_upd_idx: got %0d exp 0", upd_idx); end
      checks++; if (digit_out[3:0] !== 4'h3) begin failures++; $display("FAIL basic_digit0: got %h exp 3", digit_out[3:0]); end
      checks++; if (digit_vld !== 4'b0001) begin failures++; $display("FAIL basic_vld: got %b exp 0001", digit_vld); end
   endtask

   task automatic test_glitch_restart;
      sel_in = 4'b0100;
      seg_in = 7'b1110001;
      run_edges(20, 4, 7'b1110000);
      checks++; if (n_upd !== 1) begin failures++; $display("FAIL glitch_upd_count: got %0d exp 1", n_upd); end
      checks++; if (at_upd !== 16) begin failures++; $display("FAIL glitch_upd_edge: got %0d exp 16", at_upd); end
      checks++; if (upd_idx !== 3'd2) begin failures++; $display("FAIL glitch_upd_idx: got %0d exp 2", upd_idx); end
      checks++; if (digit_out[11:8] !== 4'hF) begin failures++; $display("FAIL glitch_digit2: got %h exp f", digit_out[11:8]); end
      checks++; if (digit_vld !== 4'b0101) begin failures++; $display("FAIL glitch_vld: got %b exp 0101", digit_vld); end
      checks++; if (n_bad !== 0) begin failures++; $display("FAIL glitch_bad_count: got %0d exp 0", n_bad); end
   endtask

   task automatic test_bad_pattern;
      sel_in = 4'b0010;
      seg_in = 7'b0000001;
      run_edges(14, -1, 7'b0);
      checks++; if (n_bad !== 1) begin failures++; $display("FAIL bad_count: got %0d exp 1", n_bad); end
      checks++; if (at_bad !== 10) begin failures++; $display("FAIL bad_edge: got %0d exp 10", at_bad); end
      checks++; if (n_upd !== 0) begin failures++; $display("FAIL bad_upd_count: got %0d exp 0", n_upd); end
      checks++; if (digit_vld !== 4'b0101) begin failures++; $display("FAIL bad_vld: got %b exp 0101", digit_vld); end
      checks++; if (upd_idx !== 3'd2) begin failures++; $display("FAIL bad_upd_idx: got %0d exp 2", upd_idx); end
`ifdef SEG_DECODER_ERRCNT_EN
      checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL bad_err_cnt: got %0d exp 1", err_cnt); end
`endif
   endtask

   task automatic test_blank;
      sel_in = 4'b0001;
      seg_in = 7'b0000000;
      run_edges(12, -1, 7'b0);
      checks++; if (n_upd !== 1) begin failures++; $display("FAIL blank_upd_count: got %0d exp 1", n_upd); end
      checks++; if (upd_idx !== 3'd0) begin failures++; $display("FAIL blank_upd_idx: got %0d exp 0", upd_idx); end
      checks++; if (digit_vld !== 4'b0100) begin failures++; $display("FAIL blank_vld: got %b exp 0100", digit_vld); end
      checks++; if (digit_out[3:0] !== 4'h3) begin failures++; $display("FAIL blank_digit0_kept: got %h exp 3", digit_out[3:0]); end
   endtask

   task automatic test_multi_select;
      sel_in = 4'b0110;
      seg_in = 7'b1111111;
      run_edges(20, -1, 7'b0);
      checks++; if (n_upd !== 0) begin failures++; $display("FAIL multi_upd_count: got %0d exp 0", n_upd); end
      checks++; if (n_bad !== 0) begin failures++; $display("FAIL multi_bad_count: got %0d exp 0", n_bad); end
      checks++; if (digit_vld !== 4'b0100) begin failures++; $display("FAIL multi_vld: got %b exp 0100", digit_vld); end
   endtask

   task automatic test_reset_mid_window;
      sel_in = 4'b1000;
      seg_in = 7'b1111111;
      run_edges(7, -1, 7'b0);
      checks++; if (n_upd !== 0) begin failures++; $display("FAIL midrst_early_upd: got %0d exp 0", n_upd); end
      rst = 1'b1;
      #1;
      checks++; if (digit_out !== 16'h0) begin failures++; $display("FAIL midrst_digit_out: got %h exp 0000", digit_out); end
      checks++; if (digit_vld !== 4'h0) begin failures++; $display("FAIL midrst_vld: got %b exp 0000", digit_vld); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_edges(14, -1, 7'b0);
      checks++; if (n_upd !== 1) begin failures++; $display("FAIL midrst_upd_count: got %0d exp 1", n_upd); end
      checks++; if (at_upd !== 10) begin failures++; $display("FAIL midrst_upd_edge: got %0d exp 10", at_upd); end
      checks++; if (upd_idx !== 3'd3) begin failures++; $display("FAIL midrst_upd_idx: got %0d exp 3", upd_idx); end
      checks++; if (digit_out !== 16'h8000) begin failures++; $display("FAIL midrst_digit_out_after: got %h exp 8000", digit_out); end
      checks++; if (digit_vld !== 4'b1000) begin failures++; $display("FAIL midrst_vld_after: got %b exp 1000", digit_vld); end
   endtask

   task automatic test_exclusive;
      checks++; if (overlap !== 0) begin failures++; $display("FAIL upd_bad_overlap: got %0d exp 0", overlap); end
   endtask

   initial begin
      test_reset;
      test_basic_commit;
      test_glitch_restart;
      test_bad_pattern;
      test_blank;
      test_multi_select;
      test_reset_mid_window;
      test_exclusive;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Reverse path of the hex-to-7-segment encoder: it monitors a multiplexed 7-segment display bus (segment lines plus one-hot digit select) and reconstructs the hex nibble shown on each digit. It sits in the stage1 test and loopback harness, where it observes the encoder/scanner outputs and checks what a board would actually display. It filters input glitches with a stability window and rejects patterns that are not valid hex glyphs.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (1..8).
- `STABLE_CYCLES`, default 8: consecutive cycles a bus value must hold before it is committed (≥2).
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `seg_in` in 7: segment lines, bit order gfedcba; 1 = lit.
- `sel_in` in DIGITS: digit select, one-hot, active-high.
- `digit_out` out 4*DIGITS: decoded nibble per digit; digit i occupies bits [4i+3:4i].
- `digit_vld` out DIGITS: 1 = digit i holds a decoded value; 0 = blank or never seen.
- `upd` out 1: one-cycle pulse on each successful commit (glyph or blank).
- `upd_idx` out 3: digit index of the last commit; held between commits.
- `bad_pat` out 1: one-cycle pulse when a stable, one-hot-selected pattern is not in the glyph table.
- `err_cnt` out 8: saturating count of bad patterns. Present only with `SEG_DECODER_ERRCNT_EN`.

## Operation
- `{sel_in, seg_in}` passes through a 2-flop synchroniser. Everything downstream uses the second flop, called `s2`.
- Stability counter:
  - Clears when `s2` differs from its previous value.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
- FSM states:
  - `IDLE`: `sel` is zero or not one-hot. The counter is held at 0 and nothing is committed.
  - `SETTLE`: `sel` is one-hot and the counter is below `STABLE_CYCLES`.
  - `LOCKED`: the value has been committed. No further commit happens until `s2` changes, which moves the FSM to `SETTLE` or `IDLE`.
- Transitions:
  - `IDLE` → `SETTLE` when `sel` becomes one-hot.
  - `SETTLE` → `LOCKED` when the counter reaches `STABLE_CYCLES`; the commit happens on this transition.
  - Any state → `IDLE` when `sel` is not one-hot.
- Glyph table:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Commit to digit idx = position of the set bit in `sel`:
  - Pattern is a glyph: `digit_out[idx]` ← nibble, `digit_vld[idx]` ← 1, `upd` pulses, `upd_idx` ← idx.
  - Pattern is 0000000 (blank): `digit_vld[idx]` ← 0, `digit_out[idx]` is retained, `upd` pulses, `upd_idx` ← idx.
  - Any other pattern: `bad_pat` pulses and digit state is unchanged. `upd` does not pulse. `upd` and `bad_pat` are never high together.
- The same value reappearing after an intermediate change commits again and pulses `upd` again.

## Timing
- Reset values: `digit_out`=0, `digit_vld`=0, `upd`=0, `upd_idx`=0, `bad_pat`=0, `err_cnt`=0. The FSM is in `IDLE`, and the synchroniser and counter are 0.
- Latency: with a new bus value held from edge 0, `upd`/`bad_pat` is high in the cycle after edge STABLE_CYCLES+2 (edge 10 at the default of 8).
- A change at any point before commit restarts the full window.
- Reset asserted mid-window clears immediately and discards the pending commit. After deassertion, a complete window is required.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `SEG_DECODER_ERRCNT_EN` defined:
  - Port `err_cnt` exists.
  - It increments by 1 on every `bad_pat` pulse and saturates at 255.
  - It is cleared only by `rst`.
- Undefined: the port and the counter logic are absent. `bad_pat` behaves identically in both builds.

## Structure
- Package `seg_pkg`:
  - The 16 glyph constants and the blank constant.
  - The segment width (7) and the nibble width (4).
  - FSM state encoding.
  - These are shared with the encoder.
- Sub-module `seg_pattern_lut`: combinational, 7-bit pattern in → {hit, blank, nibble[3:0]} out. The top level instantiates it once on `s2`'s segment field.

## Test plan
1. Reset, then hold `sel`=0001 and `seg`=1001111 for 12 cycles → a single `upd` at edge 10, `upd_idx`=0, `digit_out[3:0]`=3, `digit_vld`=0001.
2. `sel`=0100 and `seg`=1110001, but toggle `seg` to 1110000 at cycle 5 and back at cycle 6 → the commit is delayed to 10 edges after the restore; the final digit 2 = F; exactly one `upd`.
3. `sel`=0010 and `seg`=0000001 held stable → one `bad_pat` pulse, `digit_vld[1]` unchanged, and `err_cnt`=1 when the macro is defined.
4. After digit 0 = 3, hold `sel`=0001 and `seg`=0000000 → `upd` pulses, `digit_vld[0]`=0, `digit_out[3:0]` still 3.
5. `sel`=0110 (two bits set) with a valid glyph for 20 cycles → no `upd`, no `bad_pat`, FSM stays in `IDLE`.
6. Assert `rst` at cycle 7 of a window with `sel`=1000 and `seg`=1111111, release at cycle 9 → all outputs zero, and the commit occurs a full window after release.
